// File: rtl/xdma_pkg.sv
// -----------------------------------------------------------------------------
// xdma_pkg
// Shared XDMA types and helpers.
//   xdma_to_remote_grant_t : grant payload forwarded to the remote side
//   xdma_req_desc_t        : descriptor travelling with each grant
//   xdma_idx_width()       : index width for an N-entry vector, never below 1
// -----------------------------------------------------------------------------
package xdma_pkg;

  typedef logic [31:0] xdma_to_remote_grant_t;

  typedef struct packed {
    logic [7:0]  src_id;
    logic [23:0] length;
  } xdma_req_desc_t;

  // $clog2(1) is 0, which would give a zero-width index for a single requester.
  function automatic int unsigned xdma_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xdma_rr_pick.sv
// -----------------------------------------------------------------------------
// xdma_rr_pick
// Combinational round-robin picker. It searches the valid vector starting at
// the pointer and wraps from NumReq-1 back to 0.
//   valid_i [NumReq] : request bits
//   ptr_i   [IdxW]   : highest-priority index; always < NumReq
//   idx_o   [IdxW]   : first valid index at or after ptr_i (wrapping)
//   found_o          : at least one valid bit is set
// -----------------------------------------------------------------------------
module xdma_rr_pick #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] valid_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [IdxW-1:0]   idx_o,
  output logic              found_o
);

  logic [NumReq-1:0] hit;
  logic [IdxW-1:0]   cand_idx [NumReq];

  // Candidate gi is the requester reached gi steps after the pointer. The
  // extra sum bit holds ptr+gi (at most 2*NumReq-2), so one subtraction wraps it.
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_cand
    logic [IdxW:0] sum;
    assign sum          = {1'b0, ptr_i} + (IdxW+1)'(gi);
    assign cand_idx[gi] = (sum >= (IdxW+1)'(NumReq)) ? IdxW'(sum - (IdxW+1)'(NumReq))
                                                     : sum[IdxW-1:0];
    assign hit[gi]      = valid_i[cand_idx[gi]];
  end

  // The lowest rotated position wins. The loop runs downward, so the last hit
  // assigned is the one closest to the pointer.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = int'(NumReq) - 1; i >= 0; i--) begin
      if (hit[i]) begin
        found_o = 1'b1;
        idx_o   = cand_idx[i];
      end
    end
  end

endmodule

// File: rtl/xdma_grant_arbiter.sv
// -----------------------------------------------------------------------------
// xdma_grant_arbiter
// Round-robin arbiter that passes one locked requester's grant downstream and
// limits the number of grants that are in flight.
//   clk_i, rst_ni              : clock, asynchronous active-low reset
//   req_grant_i/req_desc_i     : per-requester payload and descriptor
//   req_valid_i/req_ready_o    : per-requester handshake (ready one-hot or 0)
//   grant_o/grant_desc_o       : payload/descriptor of the locked requester
//   grant_valid_o/grant_ready_i: downstream handshake
//   finish_i                   : one issued grant has completed (1-cycle pulse)
//   outstanding_o              : grants issued and not yet finished
//   busy_o                     : FSM active or grants in flight
//   err_o                      : sticky, set by finish_i with nothing in flight
// -----------------------------------------------------------------------------
module xdma_grant_arbiter #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter type xdma_to_remote_grant_t = logic,
  parameter type xdma_req_desc_t        = logic
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  xdma_to_remote_grant_t                req_grant_i [NumReq],
  input  xdma_req_desc_t                       req_desc_i  [NumReq],
  input  logic [NumReq-1:0]                    req_valid_i,
  output logic [NumReq-1:0]                    req_ready_o,
  output xdma_to_remote_grant_t                grant_o,
  output xdma_req_desc_t                       grant_desc_o,
  output logic                                 grant_valid_o,
  input  logic                                 grant_ready_i,
  input  logic                                 finish_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic                                 busy_o,
  output logic                                 err_o
);

  import xdma_pkg::*;

  localparam int unsigned     IdxW    = xdma_idx_width(NumReq);
  localparam int unsigned     CntW    = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e          state_reg,    state_next;
  logic [IdxW-1:0] lock_idx_reg, lock_idx_next;
  logic [IdxW-1:0] ptr_reg,      ptr_next;
  logic [CntW-1:0] cnt_reg,      cnt_next;
  logic            err_reg,      err_next;

  logic            pick_found;
  logic [IdxW-1:0] pick_idx;
  logic            sel_valid;
  logic            handshake;
  logic            can_arb;
  logic            finish_ok;

  xdma_rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_pick (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_reg),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign sel_valid = req_valid_i[lock_idx_reg];
  assign can_arb   = (cnt_reg < CntMax);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      lock_idx_reg <= '0;
      ptr_reg      <= '0;
      cnt_reg      <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lock_idx_reg <= lock_idx_next;
      ptr_reg      <= ptr_next;
      cnt_reg      <= cnt_next;
      err_reg      <= err_next;
    end
  end

  // Next state: lock the winner on entry to SEND. Only a completed handshake
  // advances the pointer. An abort leaves the pointer alone, so the same
  // requester stays first in line.
  always_comb begin
    state_next    = state_reg;
    lock_idx_next = lock_idx_reg;
    ptr_next      = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found && can_arb) begin
          state_next    = SEND;
          lock_idx_next = pick_idx;
        end
      end
      SEND: begin
        if (handshake) begin
          state_next = IDLE;
          ptr_next   = (lock_idx_reg == LastIdx) ? '0 : lock_idx_reg + 1'b1;
        end else if (!sel_valid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outstanding counter. A finish that arrives with nothing in flight is
  // dropped and flagged as an error. A handshake and a legal finish in the
  // same cycle cancel out. The saturation guard keeps the counter from
  // wrapping.
  always_comb begin
    finish_ok = finish_i && (cnt_reg != '0);
    err_next  = err_reg | (finish_i && (cnt_reg == '0));
    cnt_next  = cnt_reg;
    if (handshake && !finish_ok && (cnt_reg != CntMax)) begin
      cnt_next = cnt_reg + 1'b1;
    end else if (!handshake && finish_ok) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  // Outputs
  always_comb begin
    grant_valid_o = (state_reg == SEND) && sel_valid;
    handshake     = grant_valid_o && grant_ready_i;
    grant_o       = req_grant_i[lock_idx_reg];
    grant_desc_o  = req_desc_i[lock_idx_reg];
    outstanding_o = cnt_reg;
    busy_o        = (state_reg != IDLE) || (cnt_reg != '0);
    err_o         = err_reg;
  end

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_ready
    assign req_ready_o[gi] = (state_reg == SEND) && (lock_idx_reg == IdxW'(gi)) && grant_ready_i;
  end

endmodule
